rs_encode_stream_out_ctrl_multi: RTL and testbench

- Parametrised output-side controller for the streaming Reed-Solomon encoder.
- Sequences data lines from the line encoder to the destination, then handles the parity lines of each block.
- Two per-request modes:
  - append: parity is buffered in parity memory and emitted after the last block.
  - interleave: parity passes through directly after each block.
- Owns the line, block and parity address counters and drives the data/parity output mux select.

---
 rtl/rs_encode_stream_out_ctrl_multi.sv | 227 ++++++++++++++++++++++
 tb/tb_rs_encode_stream_out_ctrl_multi.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rs_encode_stream_out_ctrl_multi.sv
// Output-side controller for the streaming Reed-Solomon encoder.
// Sequences data lines, then parity either interleaved or appended from memory.
module rs_encode_stream_out_ctrl_multi #(
  parameter int DATA_LINES_PER_BLOCK   = 8,
  parameter int PARITY_LINES_PER_BLOCK = 2,
  parameter int MAX_BLOCKS             = 16,
  parameter int BLOCK_CNT_W            = $clog2(MAX_BLOCKS+1),
  parameter int PARITY_ADDR_W          =
    $clog2(MAX_BLOCKS*PARITY_LINES_PER_BLOCK)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_ctrl_out_ctrl_val,
  output logic                     out_ctrl_in_ctrl_rdy,
  input  logic [BLOCK_CNT_W-1:0]   in_ctrl_out_ctrl_num_blocks,
  input  logic                     in_ctrl_out_ctrl_interleave,
  input  logic                     line_encode_stream_encode_val,
  output logic                     stream_encode_line_encode_rdy,
  output logic                     stream_encoder_dst_resp_data_val,
  input  logic                     dst_stream_encoder_resp_data_rdy,
  output logic                     stream_encoder_dst_resp_last,
  output logic                     out_ctrl_out_datap_parity_sel,
  output logic                     parity_mem_wr_val,
  output logic [PARITY_ADDR_W-1:0] parity_mem_wr_addr,
  output logic                     parity_mem_rd_req_val,
  output logic [PARITY_ADDR_W-1:0] parity_mem_rd_req_addr,
  input  logic                     parity_mem_rd_resp_val,
  output logic                     parity_mem_rd_resp_rdy
);

  localparam int MAX_LINES =
    (DATA_LINES_PER_BLOCK > PARITY_LINES_PER_BLOCK) ?
    DATA_LINES_PER_BLOCK : PARITY_LINES_PER_BLOCK;
  localparam int LINE_W = $clog2(MAX_LINES+1);
  // One extra count so the write pointer can reach the full depth.
  localparam int ADDR_CNT_W =
    $clog2(MAX_BLOCKS*PARITY_LINES_PER_BLOCK+1);

  localparam logic [LINE_W-1:0] DATA_LAST =
    LINE_W'(DATA_LINES_PER_BLOCK-1);
  localparam logic [LINE_W-1:0] PAR_LAST =
    LINE_W'(PARITY_LINES_PER_BLOCK-1);
  localparam logic [BLOCK_CNT_W-1:0] MAX_NB =
    BLOCK_CNT_W'(MAX_BLOCKS);

  typedef enum logic [1:0] {
    READY      = 2'd0,
    DATA       = 2'd1,
    PARITY     = 2'd2,
    OUT_PARITY = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [LINE_W-1:0]      line_q, line_d;
  logic [BLOCK_CNT_W-1:0] blk_q, blk_d;
  logic [BLOCK_CNT_W-1:0] nb_q, nb_d;
  logic                   ilv_q, ilv_d;
  logic [ADDR_CNT_W-1:0]  wr_q, wr_d;
  logic [ADDR_CNT_W-1:0]  rd_q, rd_d;
  logic                   last_blk;
  logic                   line_hs;
  logic                   resp_hs;

  assign last_blk = (blk_q == nb_q - BLOCK_CNT_W'(1));
  assign line_hs  = line_encode_stream_encode_val
                  & dst_stream_encoder_resp_data_rdy;
  assign resp_hs  = parity_mem_rd_resp_val
                  & dst_stream_encoder_resp_data_rdy;

  // State, counters and latched request fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= READY;
      line_q  <= '0;
      blk_q   <= '0;
      nb_q    <= '0;
      ilv_q   <= 1'b0;
      wr_q    <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      blk_q   <= blk_d;
      nb_q    <= nb_d;
      ilv_q   <= ilv_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
    end
  end

  // Next-state, counter updates and output handshakes.
  always_comb begin
    state_d = state_q;
    line_d  = line_q;
    blk_d   = blk_q;
    nb_d    = nb_q;
    ilv_d   = ilv_q;
    wr_d    = wr_q;
    rd_d    = rd_q;

    out_ctrl_in_ctrl_rdy             = 1'b0;
    stream_encode_line_encode_rdy    = 1'b0;
    stream_encoder_dst_resp_data_val = 1'b0;
    stream_encoder_dst_resp_last     = 1'b0;
    out_ctrl_out_datap_parity_sel    = 1'b0;
    parity_mem_wr_val                = 1'b0;
    parity_mem_wr_addr               = '0;
    parity_mem_rd_req_val            = 1'b0;
    parity_mem_rd_req_addr           = '0;
    parity_mem_rd_resp_rdy           = 1'b0;

    unique case (state_q)
      READY: begin
        out_ctrl_in_ctrl_rdy = 1'b1;
        if (in_ctrl_out_ctrl_val) begin
          nb_d = (in_ctrl_out_ctrl_num_blocks == '0) ?
                 BLOCK_CNT_W'(1) : in_ctrl_out_ctrl_num_blocks;
          ilv_d   = in_ctrl_out_ctrl_interleave;
          line_d  = '0;
          blk_d   = '0;
          wr_d    = '0;
          rd_d    = '0;
          state_d = DATA;
        end
      end

      DATA: begin
        stream_encoder_dst_resp_data_val = line_encode_stream_encode_val;
        stream_encode_line_encode_rdy    = dst_stream_encoder_resp_data_rdy;
        if (line_hs) begin
          if (line_q == DATA_LAST) begin
            line_d  = '0;
            state_d = PARITY;
          end else begin
            line_d = line_q + LINE_W'(1);
          end
        end
      end

      PARITY: begin
        if (ilv_q) begin
          stream_encoder_dst_resp_data_val = line_encode_stream_encode_val;
          stream_encode_line_encode_rdy    =
            dst_stream_encoder_resp_data_rdy;
          stream_encoder_dst_resp_last     =
            line_encode_stream_encode_val & last_blk & (line_q == PAR_LAST);
          if (line_hs) begin
            if (line_q == PAR_LAST) begin
              line_d  = '0;
              blk_d   = blk_q + BLOCK_CNT_W'(1);
              state_d = last_blk ? READY : DATA;
            end else begin
              line_d = line_q + LINE_W'(1);
            end
          end
        end else begin
          stream_encode_line_encode_rdy = 1'b1;
          if (line_encode_stream_encode_val) begin
            parity_mem_wr_val  = 1'b1;
            parity_mem_wr_addr = wr_q[PARITY_ADDR_W-1:0];
            wr_d               = wr_q + ADDR_CNT_W'(1);
            if (line_q == PAR_LAST) begin
              line_d = '0;
              blk_d  = blk_q + BLOCK_CNT_W'(1);
              if (last_blk) begin
                // Memory must be write-first for the first read here.
                parity_mem_rd_req_val  = 1'b1;
                parity_mem_rd_req_addr = '0;
                rd_d                   = ADDR_CNT_W'(1);
                state_d                = OUT_PARITY;
              end else begin
                state_d = DATA;
              end
            end else begin
              line_d = line_q + LINE_W'(1);
            end
          end
        end
      end

      OUT_PARITY: begin
        out_ctrl_out_datap_parity_sel    = 1'b1;
        stream_encoder_dst_resp_data_val = parity_mem_rd_resp_val;
        parity_mem_rd_resp_rdy           = dst_stream_encoder_resp_data_rdy;
        stream_encoder_dst_resp_last     =
          parity_mem_rd_resp_val & (rd_q == wr_q);
        // Next read only after the current response drains.
        if (resp_hs) begin
          if (rd_q == wr_q) begin
            state_d = READY;
          end else begin
            parity_mem_rd_req_val  = 1'b1;
            parity_mem_rd_req_addr = rd_q[PARITY_ADDR_W-1:0];
            rd_d                   = rd_q + ADDR_CNT_W'(1);
          end
        end
      end

      default: begin
        state_d = state_t'('x);
        line_d  = 'x;
        blk_d   = 'x;
        nb_d    = 'x;
        ilv_d   = 1'bx;
        wr_d    = 'x;
        rd_d    = 'x;
        out_ctrl_in_ctrl_rdy             = 1'bx;
        stream_encode_line_encode_rdy    = 1'bx;
        stream_encoder_dst_resp_data_val = 1'bx;
        stream_encoder_dst_resp_last     = 1'bx;
        out_ctrl_out_datap_parity_sel    = 1'bx;
        parity_mem_wr_val                = 1'bx;
        parity_mem_wr_addr               = 'x;
        parity_mem_rd_req_val            = 1'bx;
        parity_mem_rd_req_addr           = 'x;
        parity_mem_rd_resp_rdy           = 1'bx;
      end
    endcase
  end

  a_nb_legal: assert property (
    @(posedge clk) disable iff (rst)
    (state_q == READY && in_ctrl_out_ctrl_val)
      |-> (in_ctrl_out_ctrl_num_blocks <= MAX_NB)
  );

endmodule

// File: tb/tb_rs_encode_stream_out_ctrl_multi.sv
// Bench for rs_encode_stream_out_ctrl_multi: vector table of requests
// plus hand sequences for mid-readout reset and back-to-back requests.
module tb_rs_encode_stream_out_ctrl_multi;

  localparam int D  = 4;
  localparam int P  = 2;
  localparam int MB = 4;
  localparam int BW = 3;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_val;
  logic          in_rdy;
  logic [BW-1:0] in_nb;
  logic          in_ilv;
  logic          line_val;
  logic          line_rdy;
  logic          dst_val;
  logic          dst_rdy;
  logic          dst_last;
  logic          psel;
  logic          wr_val;
  logic [AW-1:0] wr_addr;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rvalid;
  logic          resp_rdy;

  rs_encode_stream_out_ctrl_multi #(
    .DATA_LINES_PER_BLOCK  (D),
    .PARITY_LINES_PER_BLOCK(P),
    .MAX_BLOCKS            (MB)
  ) dut (
    .clk                              (clk),
    .rst                              (rst),
    .in_ctrl_out_ctrl_val             (in_val),
    .out_ctrl_in_ctrl_rdy             (in_rdy),
    .in_ctrl_out_ctrl_num_blocks      (in_nb),
    .in_ctrl_out_ctrl_interleave      (in_ilv),
    .line_encode_stream_encode_val    (line_val),
    .stream_encode_line_encode_rdy    (line_rdy),
    .stream_encoder_dst_resp_data_val (dst_val),
    .dst_stream_encoder_resp_data_rdy (dst_rdy),
    .stream_encoder_dst_resp_last     (dst_last),
    .out_ctrl_out_datap_parity_sel    (psel),
    .parity_mem_wr_val                (wr_val),
    .parity_mem_wr_addr               (wr_addr),
    .parity_mem_rd_req_val            (rd_req),
    .parity_mem_rd_req_addr           (rd_addr),
    .parity_mem_rd_resp_val           (rvalid),
    .parity_mem_rd_resp_rdy           (resp_rdy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit ilv;
    int nb;
    int rmode;
    int lmode;
    int total;
    int nwr;
  } vec_t;

  vec_t vecs[6];

  int n_chk = 0;
  int n_err = 0;

  int mem [8];
  int rdata;
  int cyc_ctr = 0;
  int src_idx;
  int tok_q[$];
  bit last_q[$];
  int wr_cnt;
  int rd_cnt;
  int addr_err;
  int ost_err;
  int n_acc;
  int acc_cyc;
  int last_beat_cyc;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int exp_tok(input bit ilv, input int nb, input int i);
    int j;
    if (ilv) return i;
    if (i < nb*D) return (i/D)*(D+P) + i%D;
    j = i - nb*D;
    return (j/P)*(D+P) + D + j%P;
  endfunction

  // Parity memory model: one-cycle read latency, response held until taken.
  always @(posedge clk) begin
    cyc_ctr <= cyc_ctr + 1;
    if (rst) rvalid <= 1'b0;
    else if (rd_req) begin
      rvalid <= 1'b1;
      rdata  <= mem[rd_addr];
    end else if (rvalid && resp_rdy) rvalid <= 1'b0;
  end

  // Monitor: logs beats, checks address order and outstanding reads.
  always @(negedge clk) begin
    if (!rst) begin
      if (dst_val && dst_rdy) begin
        tok_q.push_back(psel ? rdata : src_idx);
        last_q.push_back(dst_last);
        last_beat_cyc = cyc_ctr;
      end
      if (wr_val) begin
        if (wr_addr != AW'(wr_cnt)) addr_err++;
        mem[wr_addr] = src_idx;
        wr_cnt++;
      end
      if (rd_req) begin
        if (rd_addr != AW'(rd_cnt)) addr_err++;
        if (rvalid && !resp_rdy) ost_err++;
        rd_cnt++;
      end
      if (line_val && line_rdy) src_idx++;
      if (in_val && in_rdy) begin
        acc_cyc = cyc_ctr;
        n_acc++;
      end
    end
  end

  task automatic clear_logs();
    tok_q.delete();
    last_q.delete();
    src_idx  = 0;
    wr_cnt   = 0;
    rd_cnt   = 0;
    addr_err = 0;
    ost_err  = 0;
    n_acc    = 0;
  endtask

  task automatic drive_until(input int n, input int rmode,
                             input int lmode);
    int cyc = 0;
    while (tok_q.size() < n && cyc < 400) begin
      dst_rdy  = (rmode == 0) ? 1'b1 : (cyc % 2 == 0);
      line_val = (lmode == 0) ? 1'b1 : (cyc % 3 != 2);
      @(posedge clk); #1;
      cyc++;
    end
    chk("timeout", int'(cyc >= 400), 0);
  endtask

  task automatic run_req(input vec_t v);
    clear_logs();
    in_val = 1'b1;
    in_nb  = BW'(v.nb);
    in_ilv = v.ilv;
    @(posedge clk); #1;
    in_val = 1'b0;
    drive_until(v.total, v.rmode, v.lmode);
    chk("beats", tok_q.size(), v.total);
    for (int i = 0; i < tok_q.size() && i < v.total; i++) begin
      chk($sformatf("tok%0d", i), tok_q[i],
          exp_tok(v.ilv, v.total/(D+P), i));
      chk($sformatf("last%0d", i), int'(last_q[i]),
          int'(i == v.total-1));
    end
    chk("wr_cnt", wr_cnt, v.nwr);
    chk("rd_cnt", rd_cnt, v.nwr);
    chk("addr_order", addr_err, 0);
    chk("outstanding", ost_err, 0);
    chk("rdy_after", int'(in_rdy), 1);
    chk("dst_val_after", int'(dst_val), 0);
    line_val = 1'b0;
    dst_rdy  = 1'b0;
  endtask

  initial begin
    int first_last;
    vecs[0] = '{ilv:0, nb:2, rmode:0, lmode:0, total:12, nwr:4};
    vecs[1] = '{ilv:1, nb:3, rmode:0, lmode:0, total:18, nwr:0};
    vecs[2] = '{ilv:0, nb:4, rmode:1, lmode:0, total:24, nwr:8};
    vecs[3] = '{ilv:0, nb:0, rmode:0, lmode:0, total:6,  nwr:2};
    vecs[4] = '{ilv:1, nb:4, rmode:1, lmode:1, total:24, nwr:0};
    vecs[5] = '{ilv:0, nb:3, rmode:1, lmode:1, total:18, nwr:6};

    rst      = 1'b1;
    in_val   = 1'b0;
    in_nb    = '0;
    in_ilv   = 1'b0;
    line_val = 1'b0;
    dst_rdy  = 1'b0;
    clear_logs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rdy", int'(in_rdy), 1);
    chk("rst_dst_val", int'(dst_val), 0);
    chk("rst_line_rdy", int'(line_rdy), 0);
    chk("rst_psel", int'(psel), 0);
    chk("rst_wr_val", int'(wr_val), 0);
    chk("rst_rd_req", int'(rd_req), 0);
    chk("rst_resp_rdy", int'(resp_rdy), 0);
    chk("rst_last", int'(dst_last), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    for (int k = 0; k < 6; k++) begin
      run_req(vecs[k]);
      @(posedge clk); #1;
    end

    // Reset while the second parity beat is being presented.
    clear_logs();
    in_val = 1'b1;
    in_nb  = BW'(1);
    in_ilv = 1'b0;
    @(posedge clk); #1;
    in_val = 1'b0;
    drive_until(5, 0, 0);
    chk("pre_rst_psel", int'(psel), 1);
    rst     = 1'b1;
    dst_rdy = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("post_rst_rdy", int'(in_rdy), 1);
    chk("post_rst_dst_val", int'(dst_val), 0);
    chk("post_rst_psel", int'(psel), 0);
    chk("post_rst_beats", tok_q.size(), 5);
    line_val = 1'b0;
    run_req('{ilv:1, nb:1, rmode:0, lmode:0, total:6, nwr:0});
    @(posedge clk); #1;

    // Back-to-back: val held high across the first request.
    clear_logs();
    in_val = 1'b1;
    in_nb  = BW'(1);
    in_ilv = 1'b0;
    @(posedge clk); #1;
    in_nb  = BW'(2);
    in_ilv = 1'b1;
    drive_until(6, 0, 0);
    first_last = last_beat_cyc;
    chk("b2b_rdy_gap", int'(in_rdy), 1);
    @(posedge clk); #1;
    in_val = 1'b0;
    chk("b2b_accepts", n_acc, 2);
    chk("b2b_accept_cyc", acc_cyc, first_last + 1);
    drive_until(18, 0, 0);
    chk("b2b_beats", tok_q.size(), 18);
    for (int i = 0; i < tok_q.size() && i < 18; i++) begin
      chk($sformatf("b2b_tok%0d", i), tok_q[i], i);
      chk($sformatf("b2b_last%0d", i), int'(last_q[i]),
          int'(i == 5 || i == 17));
    end
    chk("b2b_wr_cnt", wr_cnt, 2);
    chk("b2b_rd_cnt", rd_cnt, 2);
    chk("b2b_rdy_after", int'(in_rdy), 1);
    line_val = 1'b0;
    dst_rdy  = 1'b0;
    repeat (2) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
